// File: rtl/seq_pkg.sv
// Shared constants for the micro sequencer: halt source and flag indices,
// and the default fetch/interrupt-entry opcodes.
package seq_pkg;
  localparam int HALT_GPU    = 0;
  localparam int HALT_DUBDAB = 1;
  localparam int HALT_MS     = 2;
  localparam int HALT_US     = 3;
  localparam int HALT_FTU    = 4;
  localparam int HALT_SPARE  = 5;

  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_ZERO    = 1;
  localparam int FLAG_GREATER = 2;
  localparam int FLAG_EQUAL   = 3;

  localparam int DEF_FETCH_OPCODE = 0;
  localparam int DEF_IRQ_OPCODE   = 63;
  localparam int STALL_CNT_W      = 16;
endpackage

// File: rtl/stall_monitor.sv
// Counts the length of the current stall run (saturating) and raises a sticky
// timeout once a run reaches the configured length.
module stall_monitor
  import seq_pkg::*;
#(
  parameter int STALL_TIMEOUT = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   stalled,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   stall_timeout
);
  localparam logic [STALL_CNT_W-1:0] TMO_M1  = STALL_CNT_W'(STALL_TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      stall_count   <= '0;
      stall_timeout <= 1'b0;
    end else if (stalled) begin
      if (stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
      // Count is pre-increment here, so this fires on the STALL_TIMEOUT-th stalled edge
      if (stall_count == TMO_M1) stall_timeout <= 1'b1;
    end else begin
      stall_count <= '0;
    end
  end
endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: steps the micro-address, alternates fetch/execute
// opcodes, takes conditional micro-branches and enters interrupts between instructions.
module micro_sequencer
  import seq_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int UADDR_W       = 6,
  parameter int N_HALT        = 6,
  parameter int N_FLAGS       = 4,
  parameter int FETCH_OPCODE  = DEF_FETCH_OPCODE,
  parameter int IRQ_OPCODE    = DEF_IRQ_OPCODE,
  parameter int STALL_TIMEOUT = 16'hFFFF
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic [OPCODE_W-1:0]        instr_in,
  input  logic                       end_micro,
  input  logic                       ubranch,
  input  logic [UADDR_W-1:0]         ubranch_target,
  input  logic [$clog2(N_FLAGS)-1:0] ubranch_sel,
  input  logic                       ubranch_inv,
  input  logic [N_FLAGS-1:0]         flags,
  input  logic                       halt_uncond,
  input  logic [N_HALT-1:0]          halt_en,
  input  logic [N_HALT-1:0]          busy,
  input  logic                       irq,
  input  logic                       irq_en,
  output logic [OPCODE_W-1:0]        opcode,
  output logic [UADDR_W-1:0]         micro_addr,
  output logic                       stalled,
  output logic                       irq_ack,
  output logic                       ucode_overrun,
  output logic                       stall_timeout,
  output logic [STALL_CNT_W-1:0]     stall_count
);
  localparam int SEL_W = $clog2(N_FLAGS);
  localparam logic [OPCODE_W-1:0] FETCH_OP = OPCODE_W'(FETCH_OPCODE);
  localparam logic [OPCODE_W-1:0] IRQ_OP   = OPCODE_W'(IRQ_OPCODE);
  localparam logic [SEL_W:0]      NF       = (SEL_W+1)'(N_FLAGS);

  logic                irq_pending;
  logic [OPCODE_W-1:0] opcode_nxt;
  logic [UADDR_W-1:0]  uaddr_nxt;
  logic                pend_nxt, ack_nxt, ovr_nxt;
  logic                flag_val, br_taken, boundary;

  assign stalled  = halt_uncond | (|(halt_en & busy));
  // An out-of-range selector reads as a 0 flag
  assign flag_val = ({1'b0, ubranch_sel} < NF) ? flags[ubranch_sel] : 1'b0;
  assign br_taken = ubranch & (flag_val ^ ubranch_inv);

  always_comb begin
    opcode_nxt = opcode;
    uaddr_nxt  = micro_addr;
    pend_nxt   = irq_pending | irq;
    ack_nxt    = 1'b0;
    ovr_nxt    = ucode_overrun;
    boundary   = 1'b0;
    if (!stalled) begin
      if (end_micro)       boundary  = 1'b1;
      else if (br_taken)   uaddr_nxt = ubranch_target;
      else if (&micro_addr) begin
        boundary = 1'b1;
        ovr_nxt  = 1'b1;
      end else             uaddr_nxt = micro_addr + 1'b1;

      if (boundary) begin
        uaddr_nxt = '0;
        if (opcode != FETCH_OP) opcode_nxt = FETCH_OP;
        else if (irq_pending && irq_en) begin
          // A still-high level irq re-arms immediately so it re-enters after the next fetch
          opcode_nxt = IRQ_OP;
          pend_nxt   = irq;
          ack_nxt    = 1'b1;
        end else opcode_nxt = instr_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      opcode        <= FETCH_OP;
      micro_addr    <= '0;
      irq_pending   <= 1'b0;
      irq_ack       <= 1'b0;
      ucode_overrun <= 1'b0;
    end else begin
      opcode        <= opcode_nxt;
      micro_addr    <= uaddr_nxt;
      irq_pending   <= pend_nxt;
      irq_ack       <= ack_nxt;
      ucode_overrun <= ovr_nxt;
    end
  end

  stall_monitor #(.STALL_TIMEOUT(STALL_TIMEOUT)) u_stall_monitor (
    .clk           (clk),
    .n_reset       (n_reset),
    .stalled       (stalled),
    .stall_count   (stall_count),
    .stall_timeout (stall_timeout)
  );
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Parametrised microcode sequencer: the next-generation CPU control unit.
- Tracks current opcode and micro-address.
- Alternates fetch and execute opcodes; gates progress on a masked set of busy/halt sources.
- Adds over the previous control unit: conditional micro-branches, interrupt entry at instruction boundaries, micro-address overrun trap, and a stall counter with timeout detection.
- Sits between the instruction register, the microcode ROM decoder and the peripheral busy lines (GPU, double dabbler, timers, FTU).

Parameters:
- OPCODE_W, 6, opcode width.
- UADDR_W, 6, micro-address width.
- N_HALT, 6, number of conditional halt sources.
- N_FLAGS, 4, number of branch condition flags.
- FETCH_OPCODE, 0, opcode of the fetch (NXI) microprogram.
- IRQ_OPCODE, 63, opcode of the interrupt-entry microprogram.
- STALL_TIMEOUT, 16'hFFFF, consecutive stall cycles before the timeout flag is set.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_reset  in  1  synchronous active-low reset.
- instr_in  in  OPCODE_W  instruction register contents.
- end_micro  in  1  current micro-word is ENDMICRO.
- ubranch  in  1  current micro-word requests a conditional branch.
- ubranch_target  in  UADDR_W  branch destination micro-address.
- ubranch_sel  in  $clog2(N_FLAGS)  index of the flag tested.
- ubranch_inv  in  1  branch taken when the selected flag is 0.
- flags  in  N_FLAGS  condition flags (carry, zero, greater, equal).
- halt_uncond  in  1  unconditional halt (hlt_cpu).
- halt_en  in  N_HALT  per-source halt enable from the micro-word.
- busy  in  N_HALT  per-source busy from the peripherals.
- irq  in  1  level interrupt request.
- irq_en  in  1  global interrupt enable.
- opcode  out  OPCODE_W  current opcode, feeds the microcode ROM.
- micro_addr  out  UADDR_W  current micro-address.
- stalled  out  1  combinational: halt active this cycle.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- ucode_overrun  out  1  sticky overrun trap.
- stall_timeout  out  1  sticky timeout flag.
- stall_count  out  16  saturating count of the current stall run.

Behaviour:
- Reset (n_reset=0 at a clk edge) sets:
  - opcode=FETCH_OPCODE, micro_addr=0.
  - irq_pending=0, irq_ack=0.
  - ucode_overrun=0, stall_timeout=0, stall_count=0.
- stalled = halt_uncond | |(halt_en & busy). Purely combinational.
- When stalled=1:
  - opcode, micro_addr and irq_ack(=0) hold.
  - stall_count increments, saturating at 16'hFFFF.
  - When stall_count reaches STALL_TIMEOUT-1 while still stalled, stall_timeout sets on that edge.
  - Stalling overrides end_micro and ubranch in the same cycle.
- When stalled=0: stall_count clears to 0, and exactly one of the following applies, in priority order:
  1. end_micro=1: micro_addr<=0, then:
     - opcode != FETCH_OPCODE: opcode<=FETCH_OPCODE.
     - else if irq_pending & irq_en: opcode<=IRQ_OPCODE, irq_pending<=0 (unless irq is still high), irq_ack<=1 for one cycle.
     - else: opcode<=instr_in.
  2. ubranch=1 and (flags[ubranch_sel] ^ ubranch_inv)=1: micro_addr<=ubranch_target. A not-taken branch falls through to rule 3.
  3. micro_addr == 2^UADDR_W-1 (no end_micro): treat as end_micro per rule 1 and set ucode_overrun (sticky).
  4. Otherwise micro_addr<=micro_addr+1.
- irq_pending:
  - Sets on any cycle with irq=1, including stalled cycles.
  - Sampled only at a fetch-complete boundary, so an interrupt never splits an execute microprogram.
  - Level irq held high re-enters only after the IRQ microprogram and the following fetch complete.
- irq_ack is registered; it is 1 only in the cycle after entry.
- Latency: one clk from end_micro to the new opcode being visible. No bubble cycles.
- ubranch_sel out of range (>= N_FLAGS) is treated as flag=0.
- Sticky flags clear only on reset.

Decomposition:
- Shared package seq_pkg holds:
  - halt source index localparams (HALT_GPU, HALT_DUBDAB, HALT_MS, HALT_US, HALT_FTU, HALT_SPARE).
  - flag index localparams (FLAG_CARRY, FLAG_ZERO, FLAG_GREATER, FLAG_EQUAL).
  - default FETCH/IRQ opcode constants.
- One natural sub-module, stall_monitor: the stall counter, saturation and timeout flag. Inputs are clk, n_reset, stalled.
- The opcode decoder remains external.

Test Plan:
- Reset, then a fetch program ending at micro_addr=3 with instr_in=6'h12 -> opcode=6'h12, micro_addr=0 one clk after end_micro; the next end_micro returns opcode to FETCH_OPCODE.
- halt_en[2]=1, busy[2] high for 5 cycles mid-program at micro_addr=4 -> micro_addr held at 4, stall_count counts 1..5 then 0, and micro_addr=5 on the first unstalled edge. With busy high but halt_en=0 -> no stall.
- ubranch=1, target=6'h20, flags=4'b0010, sel=1, inv=0 -> micro_addr=6'h20. Same with inv=1 -> micro_addr+1.
- irq pulsed during an execute program, irq_en=1 -> execute completes, fetch completes, then opcode=IRQ_OPCODE, irq_ack=1 for one cycle. With irq_en=0 -> instr_in is loaded instead.
- No end_micro for 64 cycles with UADDR_W=6 -> at micro_addr=63 the sequencer wraps to 0, switches opcode, and ucode_overrun=1 persists until reset.
- STALL_TIMEOUT=8, halt_uncond held 10 cycles -> stall_timeout=1 after the 8th stalled edge. n_reset low mid-stall -> all outputs return to their reset values on the next edge.
